writeback_stage: RTL and testbench

Retirement stage directly downstream of the two-cycle execution unit. Carries each issued uop's destination register alongside it for the execution latency, pairs it with the execution result, and drives the integer register-file write port one cycle later. Holds a pending-write scoreboard that stalls the decoder on RAW/WAW hazards, keeps a retired-instruction counter, and flags result/tag misalignment.

---
 rtl/writeback_stage_pkg.sv | 7 +
 rtl/wb_scoreboard.sv | 30 +++
 rtl/writeback_stage.sv | 80 ++++++++
 tb/tb_writeback_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared widths and latency defaults for the writeback slice
package writeback_stage_pkg;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_REG_ADDR_WIDTH = 5;
  localparam int WB_NUM_REGS = 32;
  localparam int WB_EXE_LATENCY = 2;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write mask with RAW/WAW hazard decode for the decoder
module wb_scoreboard import writeback_stage_pkg::*; #(
  parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_idx,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_idx,
  input  logic                      uop_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rd_we,
  output logic                      hazard_stall
);
  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    set_mask[set_idx] = set_en && (set_idx != '0);
    clr_mask[clr_idx] = clr_en;
  end
  // set wins over a simultaneous clear of the same index
  always_ff @(posedge clk)
    pending <= reset ? '0 : (pending & ~clr_mask) | set_mask;
  assign hazard_stall = uop_valid & (pending[rs1_addr] | pending[rs2_addr] | (rd_we & pending[rd_addr]));
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: tags results with their rd across the execution latency and drives the RF write port
module writeback_stage import writeback_stage_pkg::*; #(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
  parameter int EXE_LATENCY = WB_EXE_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uop_valid_in,
  input  logic                      system_stall,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      rd_we_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0]     exe_result,
  input  logic                      exe_result_valid,
  output logic                      rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0]     rf_wr_data,
  output logic                      hazard_stall,
  output logic                      align_error,
  output logic [31:0]               retired_count
);
  logic [EXE_LATENCY-1:0] line_valid, line_we;
  logic [EXE_LATENCY-1:0][REG_ADDR_WIDTH-1:0] line_rd;
  logic accept, tail_valid, tail_we, commit, misaligned, clr_en;
  logic [REG_ADDR_WIDTH-1:0] tail_rd, clr_idx;
  assign accept = uop_valid_in & ~system_stall & ~hazard_stall;
  assign tail_valid = line_valid[EXE_LATENCY-1];
  assign tail_we = line_we[EXE_LATENCY-1];
  assign tail_rd = line_rd[EXE_LATENCY-1];
  assign commit = tail_valid & exe_result_valid;
  assign misaligned = tail_valid ^ exe_result_valid;
  // the line never stalls because execution never stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid <= '0;
      line_we <= '0;
      line_rd <= '0;
      rf_wr_en <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      align_error <= 1'b0;
      retired_count <= '0;
      clr_en <= 1'b0;
      clr_idx <= '0;
    end else begin
      line_valid[0] <= accept;
      line_we[0] <= rd_we_in;
      line_rd[0] <= rd_in;
      for (int i = 1; i < EXE_LATENCY; i++) begin
        line_valid[i] <= line_valid[i-1];
        line_we[i] <= line_we[i-1];
        line_rd[i] <= line_rd[i-1];
      end
      rf_wr_en <= commit & tail_we & (tail_rd != '0);
      rf_wr_addr <= commit ? tail_rd : rf_wr_addr;
      rf_wr_data <= commit ? exe_result : rf_wr_data;
      align_error <= align_error | misaligned;
      retired_count <= retired_count + 32'(commit);
      clr_en <= tail_valid & tail_we;
      clr_idx <= tail_rd;
    end
  end
  // pending bit drops on the edge that ends the RF write cycle
  wb_scoreboard #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .NUM_REGS(2**REG_ADDR_WIDTH)) u_scoreboard (
    .clk(clk),
    .reset(reset),
    .set_en(accept & rd_we_in),
    .set_idx(rd_in),
    .clr_en(clr_en),
    .clr_idx(clr_idx),
    .uop_valid(uop_valid_in),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd_addr(rd_in),
    .rd_we(rd_we_in),
    .hazard_stall(hazard_stall)
  );
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed checks of commit timing, hazards, misalignment, wrap and reset
module tb_writeback_stage;
  logic clk = 1'b0;
  logic reset, uop_valid_in, system_stall, rd_we_in, exe_result_valid;
  logic [4:0] rd_in, rs1_addr, rs2_addr;
  logic [31:0] exe_result;
  logic rf_wr_en, hazard_stall, align_error;
  logic [4:0] rf_wr_addr;
  logic [31:0] rf_wr_data, retired_count;
  int passed = 0;
  int total = 0;

  writeback_stage dut (
    .clk(clk), .reset(reset), .uop_valid_in(uop_valid_in), .system_stall(system_stall),
    .rd_in(rd_in), .rd_we_in(rd_we_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .exe_result(exe_result), .exe_result_valid(exe_result_valid),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .hazard_stall(hazard_stall), .align_error(align_error), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    uop_valid_in = 1'b0;
    system_stall = 1'b0;
    rd_in = '0;
    rd_we_in = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    exe_result_valid = 1'b0;
    exe_result = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we);
    idle();
    uop_valid_in = 1'b1;
    rd_in = rd;
    rd_we_in = we;
  endtask

  task automatic result(input logic [31:0] d);
    exe_result_valid = 1'b1;
    exe_result = d;
  endtask

  // looks at pending[rs] without letting anything issue
  task automatic probe(input logic [4:0] rs, input logic exp, input string tag);
    uop_valid_in = 1'b1;
    system_stall = 1'b1;
    rd_we_in = 1'b0;
    rs1_addr = rs;
    #1;
    chk(tag, 32'(hazard_stall), 32'(exp));
    uop_valid_in = 1'b0;
    system_stall = 1'b0;
    rs1_addr = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", 32'(rf_wr_en), 0);
    chk("rst_wr_addr", 32'(rf_wr_addr), 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_align", 32'(align_error), 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_hazard", 32'(hazard_stall), 0);
    reset = 1'b0;
    tick();
    // single uop rd=5
    issue(5, 1'b1);
    tick();
    idle();
    probe(5, 1'b1, "single_pend_t1");
    tick();
    idle();
    result(32'h1234_5678);
    tick();
    idle();
    chk("single_wr_en", 32'(rf_wr_en), 1);
    chk("single_wr_addr", 32'(rf_wr_addr), 5);
    chk("single_wr_data", rf_wr_data, 32'h1234_5678);
    chk("single_retired", retired_count, 1);
    probe(5, 1'b1, "single_pend_t3");
    tick();
    chk("single_wr_en_t4", 32'(rf_wr_en), 0);
    probe(5, 1'b0, "single_pend_t4");
    tick();
    // RAW on rd=3, dependent uop writes rd=4
    issue(3, 1'b1);
    tick();
    idle();
    uop_valid_in = 1'b1;
    rs1_addr = 3;
    rd_in = 4;
    rd_we_in = 1'b1;
    #1;
    chk("raw_stall_t1", 32'(hazard_stall), 1);
    tick();
    result(32'hAAAA_0003);
    #1;
    chk("raw_stall_t2", 32'(hazard_stall), 1);
    tick();
    exe_result_valid = 1'b0;
    #1;
    chk("raw_stall_t3", 32'(hazard_stall), 1);
    chk("raw_wr_en_t3", 32'(rf_wr_en), 1);
    chk("raw_wr_addr_t3", 32'(rf_wr_addr), 3);
    chk("raw_wr_data_t3", rf_wr_data, 32'hAAAA_0003);
    tick();
    #1;
    chk("raw_stall_t4", 32'(hazard_stall), 0);
    tick();
    idle();
    probe(4, 1'b1, "raw_rd4_pend");
    tick();
    idle();
    result(32'hBBBB_0004);
    tick();
    idle();
    chk("raw2_wr_en", 32'(rf_wr_en), 1);
    chk("raw2_wr_addr", 32'(rf_wr_addr), 4);
    chk("raw2_wr_data", rf_wr_data, 32'hBBBB_0004);
    chk("raw2_retired", retired_count, 3);
    tick();
    // WAW on rd=7
    issue(7, 1'b1);
    tick();
    idle();
    uop_valid_in = 1'b1;
    rd_in = 7;
    rd_we_in = 1'b1;
    #1;
    chk("waw_stall", 32'(hazard_stall), 1);
    system_stall = 1'b1;
    rd_we_in = 1'b0;
    #1;
    chk("waw_no_we_no_stall", 32'(hazard_stall), 0);
    tick();
    idle();
    result(32'h0000_0077);
    tick();
    idle();
    chk("waw_wr_addr", 32'(rf_wr_addr), 7);
    chk("waw_retired", retired_count, 4);
    tick();
    // x0 destination
    issue(0, 1'b1);
    #1;
    chk("x0_issue_stall", 32'(hazard_stall), 0);
    tick();
    idle();
    uop_valid_in = 1'b1;
    system_stall = 1'b1;
    rd_we_in = 1'b1;
    #1;
    chk("x0_no_pend", 32'(hazard_stall), 0);
    tick();
    idle();
    result(32'hDEAD_BEEF);
    tick();
    idle();
    chk("x0_no_write", 32'(rf_wr_en), 0);
    chk("x0_retired", retired_count, 5);
    tick();
    // system_stall blocks bookkeeping, rd=10 still retires
    issue(10, 1'b1);
    tick();
    idle();
    system_stall = 1'b1;
    uop_valid_in = 1'b1;
    rd_in = 11;
    rd_we_in = 1'b1;
    tick();
    result(32'h0000_00A0);
    tick();
    exe_result_valid = 1'b0;
    #1;
    chk("stall_wr_en", 32'(rf_wr_en), 1);
    chk("stall_wr_addr", 32'(rf_wr_addr), 10);
    chk("stall_retired", retired_count, 6);
    tick();
    idle();
    chk("stall_no_wr_t4", 32'(rf_wr_en), 0);
    probe(11, 1'b0, "stall_no_pend");
    tick();
    chk("stall_no_wr_t5", 32'(rf_wr_en), 0);
    chk("stall_align", 32'(align_error), 0);
    // result with an empty tail
    result(32'h0000_0055);
    tick();
    idle();
    chk("mis_empty_align", 32'(align_error), 1);
    chk("mis_empty_no_wr", 32'(rf_wr_en), 0);
    chk("mis_empty_retired", retired_count, 6);
    tick();
    chk("mis_sticky", 32'(align_error), 1);
    // valid tail rd=9 with no result
    issue(9, 1'b1);
    tick();
    idle();
    probe(9, 1'b1, "mis9_pend_t1");
    tick();
    tick();
    chk("mis9_no_wr", 32'(rf_wr_en), 0);
    chk("mis9_retired", retired_count, 6);
    probe(9, 1'b1, "mis9_pend_t3");
    tick();
    probe(9, 1'b0, "mis9_pend_cleared");
    chk("mis9_align", 32'(align_error), 1);
    // counter wrap
    force dut.retired_count = 32'hFFFF_FFFF;
    #2;
    release dut.retired_count;
    tick();
    chk("wrap_preload", retired_count, 32'hFFFF_FFFF);
    issue(12, 1'b1);
    tick();
    idle();
    tick();
    result(32'h0000_000C);
    tick();
    idle();
    chk("wrap_zero", retired_count, 0);
    chk("wrap_wr_addr", 32'(rf_wr_addr), 12);
    tick();
    // reset with two uops in flight
    issue(13, 1'b1);
    tick();
    issue(14, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_wr_en", 32'(rf_wr_en), 0);
    chk("rr_wr_addr", 32'(rf_wr_addr), 0);
    chk("rr_wr_data", rf_wr_data, 0);
    chk("rr_align", 32'(align_error), 0);
    chk("rr_retired", retired_count, 0);
    probe(13, 1'b0, "rr_pend13");
    probe(14, 1'b0, "rr_pend14");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_no_wr_after", 32'(rf_wr_en), 0);
    end
    chk("rr_retired_after", retired_count, 0);
    chk("rr_align_after", 32'(align_error), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
